// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side arbiter: Gray/binary
// conversion, read FSM states and the number of read requesters.
package fifo_pkg;

  localparam int NUM_RD_REQ = 2;
  localparam int MAX_PTR_W  = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } rd_state_e;

  // Callers zero-extend narrower pointers; the conversions are width-safe.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rr_arb.sv
// Two-way round-robin grant: with both requesters active, the one not
// granted most recently wins. Purely combinational.
module fifo_rr_arb
  import fifo_pkg::*;
(
  input  logic [NUM_RD_REQ-1:0] req,
  input  logic                  enable,
  input  logic                  last_gnt,
  output logic [NUM_RD_REQ-1:0] gnt
);

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned and infers a latch.
  always_comb begin
    gnt = '0;
    if (enable) begin
      if (req == 2'b11) begin
        gnt = last_gnt ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arb.sv
// Read-domain side of an async FIFO with a two-consumer round-robin arbiter
// and flush handling. Optional almost-empty flag: define FIFO_RD_AEMPTY_EN.
module fifo_rd_arb
  import fifo_pkg::*;
#(
  parameter int DEPTH     = 7,
  parameter int AE_THRESH = 2
) (
  input  logic                  clk_out,
  input  logic                  reset,
  input  logic [DEPTH:0]        w2rsync2_ptr,
  input  logic                  flush_out,
  input  logic [NUM_RD_REQ-1:0] req,
  output logic [NUM_RD_REQ-1:0] gnt,
  output logic                  rd_en,
  output logic [DEPTH-1:0]      rd_addr,
  output logic [DEPTH:0]        rd_ptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  flush_done
);

  localparam int PW = DEPTH + 1;

  rd_state_e         state, state_next;
  logic [PW-1:0]     rbin, rbin_next, rgray_next, wbin;
  logic              last_gnt;
  logic              grant_en;

  assign grant_en = (state == RUN) && !flush_out && !empty;

  fifo_rr_arb u_rr_arb (
    .req      (req),
    .enable   (grant_en),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  assign rd_en      = |gnt;
  assign rd_addr    = rbin[DEPTH-1:0];
  assign rbin_next  = rbin + PW'(rd_en);
  assign rgray_next = PW'(bin2gray(MAX_PTR_W'(rbin_next)));
  assign wbin       = PW'(gray2bin(MAX_PTR_W'(w2rsync2_ptr)));
  assign flush_done = (state == DONE);

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (flush_out)  state_next = FLUSH;
      FLUSH:   if (!flush_out) state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // last_gnt resets to 1 so requester 0 holds priority after reset.
  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      rbin        <= '0;
      rd_ptr_gray <= '0;
      empty       <= 1'b1;
      last_gnt    <= 1'b1;
    end else if (state == FLUSH) begin
      rbin        <= wbin;
      rd_ptr_gray <= w2rsync2_ptr;
      empty       <= 1'b1;
    end else begin
      rbin        <= rbin_next;
      rd_ptr_gray <= rgray_next;
      empty       <= (rgray_next == w2rsync2_ptr);
      if (rd_en) last_gnt <= gnt[1];
    end
  end

`ifdef FIFO_RD_AEMPTY_EN
  logic [PW-1:0] occupancy;

  // After a flush the read pointer equals the write pointer: occupancy 0.
  assign occupancy = (state == FLUSH) ? '0 : (wbin - rbin_next);

  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      almost_empty <= 1'b1;
    end else begin
      almost_empty <= (occupancy <= PW'(AE_THRESH));
    end
  end
`else
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Directed bench for fifo_rd_arb: a cycle-by-cycle vector table on the
// default instance plus hand sequences for almost-empty and DEPTH=2 wrap.
module tb_fifo_rd_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] w;
  logic       f;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       rd_en, e, ae, done;
  logic [6:0] addr;
  logic [7:0] g;

  logic [2:0] w2;
  logic       f2;
  logic [1:0] req2, gnt2;
  logic       rd_en2, e2, ae2, done2;
  logic [1:0] addr2;
  logic [2:0] g2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_rd_arb #(.DEPTH(7), .AE_THRESH(2)) dut (
    .clk_out(clk), .reset(rst), .w2rsync2_ptr(w), .flush_out(f), .req(req),
    .gnt(gnt), .rd_en(rd_en), .rd_addr(addr), .rd_ptr_gray(g),
    .empty(e), .almost_empty(ae), .flush_done(done)
  );

  fifo_rd_arb #(.DEPTH(2), .AE_THRESH(2)) dut2 (
    .clk_out(clk), .reset(rst), .w2rsync2_ptr(w2), .flush_out(f2), .req(req2),
    .gnt(gnt2), .rd_en(rd_en2), .rd_addr(addr2), .rd_ptr_gray(g2),
    .empty(e2), .almost_empty(ae2), .flush_done(done2)
  );

  typedef struct packed {
    logic       rst;
    logic [7:0] w;
    logic       f;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       e;
    logic [7:0] g;
    logic [6:0] a;
    logic       d;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] wv, input logic fv, input logic [1:0] rq);
    @(negedge clk);
    rst = r; w = wv; f = fv; req = rq;
    #1;
  endtask

  task automatic step2(input logic [2:0] wv, input logic fv, input logic [1:0] rq);
    @(negedge clk);
    w2 = wv; f2 = fv; req2 = rq;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; w = '0; f = 1'b0; req = 2'b11;
    w2 = '0; f2 = 1'b0; req2 = 2'b00;

    //            rst   w      f     req    gnt    e     g      a     d
    vecs[0]  = '{1'b0, 8'd0,  1'b0, 2'b11, 2'b00, 1'b1, 8'd0,  7'd0, 1'b0};
    vecs[1]  = '{1'b1, 8'd0,  1'b0, 2'b11, 2'b00, 1'b1, 8'd0,  7'd0, 1'b0};
    vecs[2]  = '{1'b1, 8'd2,  1'b0, 2'b01, 2'b00, 1'b1, 8'd0,  7'd0, 1'b0};
    vecs[3]  = '{1'b1, 8'd2,  1'b0, 2'b01, 2'b01, 1'b0, 8'd0,  7'd0, 1'b0};
    vecs[4]  = '{1'b1, 8'd2,  1'b0, 2'b01, 2'b01, 1'b0, 8'd1,  7'd1, 1'b0};
    vecs[5]  = '{1'b1, 8'd2,  1'b0, 2'b01, 2'b01, 1'b0, 8'd3,  7'd2, 1'b0};
    vecs[6]  = '{1'b1, 8'd2,  1'b0, 2'b01, 2'b00, 1'b1, 8'd2,  7'd3, 1'b0};
    vecs[7]  = '{1'b0, 8'd0,  1'b0, 2'b11, 2'b00, 1'b1, 8'd0,  7'd0, 1'b0};
    vecs[8]  = '{1'b1, 8'd6,  1'b0, 2'b11, 2'b00, 1'b1, 8'd0,  7'd0, 1'b0};
    vecs[9]  = '{1'b1, 8'd6,  1'b0, 2'b11, 2'b01, 1'b0, 8'd0,  7'd0, 1'b0};
    vecs[10] = '{1'b1, 8'd6,  1'b0, 2'b11, 2'b10, 1'b0, 8'd1,  7'd1, 1'b0};
    vecs[11] = '{1'b1, 8'd6,  1'b0, 2'b11, 2'b01, 1'b0, 8'd3,  7'd2, 1'b0};
    vecs[12] = '{1'b1, 8'd6,  1'b0, 2'b11, 2'b10, 1'b0, 8'd2,  7'd3, 1'b0};
    vecs[13] = '{1'b1, 8'd6,  1'b0, 2'b11, 2'b00, 1'b1, 8'd6,  7'd4, 1'b0};
    vecs[14] = '{1'b1, 8'd6,  1'b0, 2'b11, 2'b00, 1'b1, 8'd6,  7'd4, 1'b0};
    vecs[15] = '{1'b1, 8'd13, 1'b0, 2'b11, 2'b00, 1'b1, 8'd6,  7'd4, 1'b0};
    vecs[16] = '{1'b1, 8'd13, 1'b1, 2'b11, 2'b00, 1'b0, 8'd6,  7'd4, 1'b0};
    vecs[17] = '{1'b1, 8'd13, 1'b1, 2'b11, 2'b00, 1'b0, 8'd6,  7'd4, 1'b0};
    vecs[18] = '{1'b1, 8'd13, 1'b1, 2'b11, 2'b00, 1'b1, 8'd13, 7'd9, 1'b0};
    vecs[19] = '{1'b1, 8'd13, 1'b0, 2'b11, 2'b00, 1'b1, 8'd13, 7'd9, 1'b0};
    vecs[20] = '{1'b1, 8'd13, 1'b0, 2'b11, 2'b00, 1'b1, 8'd13, 7'd9, 1'b1};
    vecs[21] = '{1'b1, 8'd13, 1'b0, 2'b11, 2'b00, 1'b1, 8'd13, 7'd9, 1'b0};
    vecs[22] = '{1'b1, 8'd13, 1'b1, 2'b11, 2'b00, 1'b1, 8'd13, 7'd9, 1'b0};
    vecs[23] = '{1'b1, 8'd13, 1'b1, 2'b11, 2'b00, 1'b1, 8'd13, 7'd9, 1'b0};
    vecs[24] = '{1'b0, 8'd13, 1'b1, 2'b11, 2'b00, 1'b1, 8'd0,  7'd0, 1'b0};
    vecs[25] = '{1'b1, 8'd13, 1'b0, 2'b11, 2'b00, 1'b1, 8'd0,  7'd0, 1'b0};
    vecs[26] = '{1'b1, 8'd13, 1'b0, 2'b01, 2'b01, 1'b0, 8'd0,  7'd0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].w, vecs[i].f, vecs[i].req);
      check($sformatf("v%0d gnt", i),        gnt,   vecs[i].gnt);
      check($sformatf("v%0d rd_en", i),      rd_en, |vecs[i].gnt);
      check($sformatf("v%0d empty", i),      e,     vecs[i].e);
      check($sformatf("v%0d rd_ptr_gray", i), g,    vecs[i].g);
      check($sformatf("v%0d rd_addr", i),    addr,  vecs[i].a);
      check($sformatf("v%0d flush_done", i), done,  vecs[i].d);
`ifndef FIFO_RD_AEMPTY_EN
      check($sformatf("v%0d almost_empty", i), ae, 1'b0);
`endif
    end

    // Almost-empty: occupancy 4 -> 3 -> 2 with a single requester.
    step(1'b0, 8'd0, 1'b0, 2'b01);
`ifdef FIFO_RD_AEMPTY_EN
    check("ae reset", ae, 1'b1);
`else
    check("ae reset", ae, 1'b0);
`endif
    step(1'b1, 8'd6, 1'b0, 2'b01);
    check("ae gnt idle", gnt, 2'b00);
    step(1'b1, 8'd6, 1'b0, 2'b01);
    check("ae occ4 gnt", gnt, 2'b01);
    check("ae occ4", ae, 1'b0);
    step(1'b1, 8'd6, 1'b0, 2'b01);
    check("ae occ3 gnt", gnt, 2'b01);
    check("ae occ3", ae, 1'b0);
    step(1'b1, 8'd6, 1'b0, 2'b01);
    check("ae occ2 gnt", gnt, 2'b01);
`ifdef FIFO_RD_AEMPTY_EN
    check("ae occ2", ae, 1'b1);
`else
    check("ae occ2", ae, 1'b0);
`endif

    // DEPTH=2: flush to read pointer 6, then read across the wrap to 8, then 9.
    step2(3'b101, 1'b1, 2'b00);
    step2(3'b101, 1'b1, 2'b00);
    check("d2 flush gnt", gnt2, 2'b00);
    step2(3'b101, 1'b0, 2'b00);
    check("d2 flush gray", g2, 3'b101);
    check("d2 flush addr", addr2, 2'd2);
    check("d2 flush empty", e2, 1'b1);
    step2(3'b000, 1'b0, 2'b01);
    check("d2 done", done2, 1'b1);
    check("d2 done gnt", gnt2, 2'b00);
    step2(3'b000, 1'b0, 2'b01);
    check("d2 rd6 gnt", gnt2, 2'b01);
    check("d2 rd6 addr", addr2, 2'd2);
    check("d2 rd6 empty", e2, 1'b0);
    step2(3'b000, 1'b0, 2'b01);
    check("d2 rd7 gnt", gnt2, 2'b01);
    check("d2 rd7 addr", addr2, 2'd3);
    step2(3'b000, 1'b0, 2'b01);
    check("d2 wrap empty", e2, 1'b1);
    check("d2 wrap gnt", gnt2, 2'b00);
    check("d2 wrap gray", g2, 3'b000);
    step2(3'b001, 1'b0, 2'b01);
    check("d2 w9 stale gnt", gnt2, 2'b00);
    step2(3'b001, 1'b0, 2'b01);
    check("d2 rd8 gnt", gnt2, 2'b01);
    check("d2 rd8 addr", addr2, 2'd0);
    check("d2 rd8 empty", e2, 1'b0);
    step2(3'b001, 1'b0, 2'b01);
    check("d2 end empty", e2, 1'b1);
    check("d2 end gnt", gnt2, 2'b00);
    check("d2 end gray", g2, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
